// File: rtl/dzcpu_useq_pkg.sv
// dzcpu_useq_pkg
//   Shared definitions for the dzcpu microcode sequencer:
//   - flow-control codes carried in the top bits of every uop word
//   - sequencer state encoding
//   - mk_uop helper used when building ROM images
package dzcpu_useq_pkg;

  localparam int FLOW_CODE_W = 4;

  // Flow-control codes; 7..15 are undefined and raise the error flag.
  localparam logic [FLOW_CODE_W-1:0] FL_OP         = 4'd0;
  localparam logic [FLOW_CODE_W-1:0] FL_INC        = 4'd1;
  localparam logic [FLOW_CODE_W-1:0] FL_EOF        = 4'd2;
  localparam logic [FLOW_CODE_W-1:0] FL_INC_EOF    = 4'd3;
  localparam logic [FLOW_CODE_W-1:0] FL_INC_EOF_Z  = 4'd4;
  localparam logic [FLOW_CODE_W-1:0] FL_INC_EOF_NZ = 4'd5;
  localparam logic [FLOW_CODE_W-1:0] FL_JCB        = 4'd6;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_FETCH       = 3'd1,
    ST_DISPATCH    = 3'd2,
    ST_CB_DISPATCH = 3'd3,
    ST_EXEC        = 3'd4
  } useq_state_e;

  // Builds a default-width (12-bit) uop word from a flow code and payload.
  function automatic logic [11:0] mk_uop(input logic [FLOW_CODE_W-1:0] flow,
                                         input logic [7:0] body);
    return {flow, body};
  endfunction

endpackage

// File: rtl/dzcpu_useq_flow_decode.sv
// dzcpu_useq_flow_decode
//   Combinational decode of a uop flow-control field.
//   Ports:
//     f         in   flow field of the current uop
//     zero      in   current Z flag (resolves the conditional EOF codes)
//     cb_enable in   0 turns JCB into an illegal code
//     advance   out  uPC steps to uPC+1
//     inc_pc    out  uop requests a PC increment
//     terminal  out  uop ends the macro-instruction (illegal codes act as EOF)
//     jcb       out  CB-prefix redispatch
//     illegal   out  undefined code (or JCB while CB is disabled)
module dzcpu_useq_flow_decode
  import dzcpu_useq_pkg::*;
#(
  parameter int FLOW_W = 4
) (
  input  logic [FLOW_W-1:0] f,
  input  logic              zero,
  input  logic              cb_enable,
  output logic              advance,
  output logic              inc_pc,
  output logic              terminal,
  output logic              jcb,
  output logic              illegal
);

  always_comb begin
    advance  = 1'b0;
    inc_pc   = 1'b0;
    terminal = 1'b0;
    jcb      = 1'b0;
    illegal  = 1'b0;
    case (f)
      FLOW_W'(FL_OP): advance = 1'b1;
      FLOW_W'(FL_INC): begin
        advance = 1'b1;
        inc_pc  = 1'b1;
      end
      FLOW_W'(FL_EOF): terminal = 1'b1;
      FLOW_W'(FL_INC_EOF): begin
        inc_pc   = 1'b1;
        terminal = 1'b1;
      end
      FLOW_W'(FL_INC_EOF_Z): begin
        inc_pc   = 1'b1;
        terminal = zero;
        advance  = ~zero;
      end
      FLOW_W'(FL_INC_EOF_NZ): begin
        inc_pc   = 1'b1;
        terminal = ~zero;
        advance  = zero;
      end
      FLOW_W'(FL_JCB): begin
        if (cb_enable) begin
          jcb    = 1'b1;
          inc_pc = 1'b1;
        end else begin
          illegal  = 1'b1;
          terminal = 1'b1;
        end
      end
      default: begin
        illegal  = 1'b1;
        terminal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dzcpu_useq.sv
// dzcpu_useq
//   Microcode sequencer: owns the uPC, accepts macro-opcodes over a
//   valid/ready handshake, dispatches them through external primary/CB LUTs
//   and steps the external microcode ROM by each uop's flow field.
//   Ports:
//     iClock/iReset           clock, synchronous active-high reset
//     iOpcode/iOpValid        opcode (or CB byte) and its valid
//     oOpReady                opcode is accepted this cycle
//     oLutMop/oLutCbPage      dispatch LUT request, iLutAddr is the answer
//     oUAddr/iUopWord         ROM address (uPC) and combinational ROM data
//     oUop/oUopValid          uop body (flow stripped) and its execute qualifier
//     oIncPc                  PC increment strobe
//     iZero                   Z flag for conditional EOF
//     iStall                  memory wait; freezes opcode accept and EXEC
//     iIrqPending/oIrqAck     interrupt request / taken pulse
//     oErr                    sticky error (uPC overflow, illegal flow)
//     oBusy                   not in IDLE or FETCH
//
//   state          | meaning
//   ST_IDLE        | one cycle after reset
//   ST_FETCH       | waiting for an opcode, oOpReady=1 unless stalled
//   ST_DISPATCH    | primary LUT lookup of rMop, uPC <= iLutAddr
//   ST_CB_DISPATCH | CB LUT lookup of rMop, uPC <= iLutAddr
//   ST_EXEC        | executing uops from the ROM
module dzcpu_useq
  import dzcpu_useq_pkg::*;
#(
  parameter int                 UADDR_W   = 8,
  parameter int                 UOP_W     = 12,
  parameter int                 FLOW_W    = 4,
  parameter logic [UADDR_W-1:0] IRQ_ENTRY = UADDR_W'(8'hF0),
  parameter bit                 CB_ENABLE = 1'b1
) (
  input  logic                    iClock,
  input  logic                    iReset,
  input  logic [7:0]              iOpcode,
  input  logic                    iOpValid,
  output logic                    oOpReady,
  output logic [7:0]              oLutMop,
  output logic                    oLutCbPage,
  input  logic [UADDR_W-1:0]      iLutAddr,
  output logic [UADDR_W-1:0]      oUAddr,
  input  logic [UOP_W-1:0]        iUopWord,
  output logic [UOP_W-FLOW_W-1:0] oUop,
  output logic                    oUopValid,
  output logic                    oIncPc,
  input  logic                    iZero,
  input  logic                    iStall,
  input  logic                    iIrqPending,
  output logic                    oIrqAck,
  output logic                    oErr,
  output logic                    oBusy
);

  useq_state_e        state;
  logic [UADDR_W-1:0] upc;
  logic [7:0]         rmop;
  logic               err;

  logic [FLOW_W-1:0]  flow;
  logic               fd_advance, fd_inc_pc, fd_terminal, fd_jcb, fd_illegal;
  logic               exec_go, ovf, fault, irq_take;

  assign flow = iUopWord[UOP_W-1 -: FLOW_W];

  dzcpu_useq_flow_decode #(.FLOW_W(FLOW_W)) u_flow_decode (
    .f         (flow),
    .zero      (iZero),
    .cb_enable (CB_ENABLE),
    .advance   (fd_advance),
    .inc_pc    (fd_inc_pc),
    .terminal  (fd_terminal),
    .jcb       (fd_jcb),
    .illegal   (fd_illegal)
  );

  // Strobes are decoded from the registered state and are suppressed in a
  // reset cycle so nothing fires while the sequencer is being cleared.
  assign exec_go  = (state == ST_EXEC) && !iStall && !iReset;
  // The uPC never wraps: stepping past the top address is an error.
  assign ovf      = fd_advance && (upc == {UADDR_W{1'b1}});
  assign fault    = fd_illegal || ovf;
  assign irq_take = exec_go && fd_terminal && !fault && iIrqPending;

  // A JCB uop consumes the CB byte through the same handshake as FETCH.
  assign oOpReady   = !iReset && !iStall &&
                      ((state == ST_FETCH) || ((state == ST_EXEC) && fd_jcb));
  assign oUopValid  = exec_go;
  assign oIncPc     = exec_go && fd_inc_pc && (!fd_jcb || iOpValid);
  assign oIrqAck    = irq_take;
  assign oUop       = iUopWord[UOP_W-FLOW_W-1:0];
  assign oUAddr     = upc;
  assign oLutMop    = rmop;
  assign oLutCbPage = (state == ST_CB_DISPATCH);
  assign oErr       = err;
  assign oBusy      = (state == ST_DISPATCH) || (state == ST_CB_DISPATCH) ||
                      (state == ST_EXEC);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state <= ST_IDLE;
      upc   <= '0;
      rmop  <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: state <= ST_FETCH;
        ST_FETCH: begin
          if (!iStall && iOpValid) begin
            rmop  <= iOpcode;
            state <= ST_DISPATCH;
          end
        end
        ST_DISPATCH, ST_CB_DISPATCH: begin
          upc   <= iLutAddr;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (!iStall) begin
            if (fault) begin
              err   <= 1'b1;
              state <= ST_FETCH;
            end else if (fd_jcb) begin
              // Hold on the JCB uop until the CB byte shows up.
              if (iOpValid) begin
                rmop  <= iOpcode;
                state <= ST_CB_DISPATCH;
              end
            end else if (fd_terminal) begin
              if (iIrqPending) upc <= IRQ_ENTRY;
              else             state <= ST_FETCH;
            end else if (fd_advance) begin
              upc <= upc + UADDR_W'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_useq.sv
module tb_dzcpu_useq;
  import dzcpu_useq_pkg::*;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iOpcode = 8'h00;
  logic        iOpValid = 1'b0;
  logic        oOpReady;
  logic [7:0]  oLutMop;
  logic        oLutCbPage;
  logic [7:0]  iLutAddr;
  logic [7:0]  oUAddr;
  logic [11:0] iUopWord;
  logic [7:0]  oUop;
  logic        oUopValid, oIncPc;
  logic        iZero = 1'b0, iStall = 1'b0, iIrqPending = 1'b0;
  logic        oIrqAck, oErr, oBusy;

  logic [11:0] rom   [256];
  logic [7:0]  plut  [256];
  logic [7:0]  cblut [256];

  int n_checks = 0;
  int n_err    = 0;

  always #5 iClock = ~iClock;

  // External ROM and dispatch LUTs are plain combinational tables.
  assign iUopWord = rom[oUAddr];
  assign iLutAddr = oLutCbPage ? cblut[oLutMop] : plut[oLutMop];

  dzcpu_useq dut (
    .iClock(iClock), .iReset(iReset), .iOpcode(iOpcode), .iOpValid(iOpValid),
    .oOpReady(oOpReady), .oLutMop(oLutMop), .oLutCbPage(oLutCbPage),
    .iLutAddr(iLutAddr), .oUAddr(oUAddr), .iUopWord(iUopWord), .oUop(oUop),
    .oUopValid(oUopValid), .oIncPc(oIncPc), .iZero(iZero), .iStall(iStall),
    .iIrqPending(iIrqPending), .oIrqAck(oIrqAck), .oErr(oErr), .oBusy(oBusy)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Instruction-level view: waiting for an opcode, looking it up, or running
  // the microprogram at m_pc.
  localparam int M_BOOT = 0, M_WANT = 1, M_LOOKUP = 2, M_RUN = 3;
  int         m_mode  = M_BOOT;
  bit         m_known = 1'b0;
  bit         m_cbsel = 1'b0;
  logic [7:0] m_pc    = 8'h00;
  logic [7:0] m_mop   = 8'h00;
  bit         m_err   = 1'b0;

  function automatic void flow_rules(input logic [3:0] f, input bit z,
                                     output bit ends, output bit steps,
                                     output bit bumps, output bit cb, output bit bad);
    ends = 0; steps = 0; bumps = 0; cb = 0; bad = 0;
    case (f)
      4'd0: steps = 1;
      4'd1: begin steps = 1; bumps = 1; end
      4'd2: ends = 1;
      4'd3: begin ends = 1; bumps = 1; end
      4'd4: begin bumps = 1; ends = z;  steps = !z; end
      4'd5: begin bumps = 1; ends = !z; steps = z;  end
      4'd6: begin cb = 1; bumps = 1; end
      default: bad = 1;
    endcase
  endfunction

  always @(negedge iClock) begin : model
    bit ends, steps, bumps, cb, bad, go, e_rdy;
    logic [30:0] exp_v, act_v;
    flow_rules(rom[m_pc][11:8], iZero, ends, steps, bumps, cb, bad);
    go    = (m_mode == M_RUN) && !iStall && !iReset;
    e_rdy = !iReset && !iStall && ((m_mode == M_WANT) || ((m_mode == M_RUN) && cb));
    if (m_known) begin
      exp_v = {m_pc, rom[m_pc][7:0], go, go && bumps && (!cb || iOpValid),
               go && ends && iIrqPending, e_rdy, (m_mode == M_LOOKUP) && m_cbsel,
               m_mop, m_err, (m_mode == M_LOOKUP) || (m_mode == M_RUN)};
      act_v = {oUAddr, oUop, oUopValid, oIncPc, oIrqAck, oOpReady, oLutCbPage,
               oLutMop, oErr, oBusy};
      n_checks++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL model_cycle t=%0t got=%h expected=%h (uaddr,uop,v,inc,ack,rdy,cb,mop,err,busy)",
                 $time, act_v, exp_v);
      end
    end
    if (iReset) begin
      m_known = 1; m_mode = M_BOOT; m_pc = 8'h00; m_mop = 8'h00; m_err = 0; m_cbsel = 0;
    end else begin
      case (m_mode)
        M_BOOT: m_mode = M_WANT;
        M_WANT: if (!iStall && iOpValid) begin
          m_mop = iOpcode; m_cbsel = 0; m_mode = M_LOOKUP;
        end
        M_LOOKUP: begin
          m_pc   = m_cbsel ? cblut[m_mop] : plut[m_mop];
          m_mode = M_RUN;
        end
        default: if (!iStall) begin
          if (bad || (steps && m_pc == 8'hFF)) begin
            m_err = 1; m_mode = M_WANT;
          end else if (cb) begin
            if (iOpValid) begin m_mop = iOpcode; m_cbsel = 1; m_mode = M_LOOKUP; end
          end else if (ends) begin
            if (iIrqPending) m_pc = 8'hF0;
            else             m_mode = M_WANT;
          end else begin
            m_pc = m_pc + 8'd1;
          end
        end
      endcase
    end
  end

  // ---------------- directed trace capture ----------------
  int t_ua[32], t_v[32], t_inc[32], t_ack[32], t_rdy[32], t_cb[32], t_mop[32], t_err[32], t_busy[32];

  // Cycle i drives bit i of each mask; op0 on cycle 0, op1 afterwards.
  task automatic run_trace(input int n, input logic [7:0] op0, input logic [7:0] op1,
                           input logic [31:0] opv_m, input logic [31:0] stall_m,
                           input logic [31:0] zero_m, input logic [31:0] irq_m,
                           input logic [31:0] rst_m);
    for (int i = 0; i < n; i++) begin
      iOpcode = (i == 0) ? op0 : op1;
      iOpValid = opv_m[i]; iStall = stall_m[i]; iZero = zero_m[i];
      iIrqPending = irq_m[i]; iReset = rst_m[i];
      @(negedge iClock);
      t_ua[i] = int'(oUAddr); t_v[i] = int'(oUopValid); t_inc[i] = int'(oIncPc);
      t_ack[i] = int'(oIrqAck); t_rdy[i] = int'(oOpReady); t_cb[i] = int'(oLutCbPage);
      t_mop[i] = int'(oLutMop); t_err[i] = int'(oErr); t_busy[i] = int'(oBusy);
      @(posedge iClock); #1;
    end
    iOpValid = 0; iStall = 0; iZero = 0; iIrqPending = 0; iReset = 0;
  endtask

  function automatic logic [11:0] rand_uop();
    int r;
    logic [3:0] f;
    r = $urandom_range(0, 99);
    if      (r < 30) f = FL_OP;
    else if (r < 45) f = FL_INC;
    else if (r < 58) f = FL_EOF;
    else if (r < 68) f = FL_INC_EOF;
    else if (r < 76) f = FL_INC_EOF_Z;
    else if (r < 84) f = FL_INC_EOF_NZ;
    else if (r < 95) f = FL_JCB;
    else             f = 4'($urandom_range(7, 15));
    return mk_uop(f, 8'($urandom));
  endfunction

  initial begin
    int e_inc1[4] = '{1, 1, 0, 1};
    for (int i = 0; i < 256; i++) begin
      rom[i] = mk_uop(FL_EOF, 8'(i)); plut[i] = 8'h00; cblut[i] = 8'h00;
    end
    plut[8'h31] = 8'd1;
    rom[1] = mk_uop(FL_INC, 8'hA1); rom[2] = mk_uop(FL_INC, 8'hA2);
    rom[3] = mk_uop(FL_OP, 8'hA3);  rom[4] = mk_uop(FL_INC_EOF, 8'hA4);

    // Reset state
    @(posedge iClock); #1;
    @(negedge iClock);
    chk("rst_uaddr", int'(oUAddr), 0);   chk("rst_valid", int'(oUopValid), 0);
    chk("rst_incpc", int'(oIncPc), 0);   chk("rst_ready", int'(oOpReady), 0);
    chk("rst_err", int'(oErr), 0);       chk("rst_busy", int'(oBusy), 0);
    @(posedge iClock); #1;
    iReset = 0;
    @(negedge iClock);
    chk("idle_ready", int'(oOpReady), 0);
    @(posedge iClock); #1;

    // Straight flow INC,INC,OP,INC_EOF
    run_trace(8, 8'h31, 8'h00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t1_accept_rdy", t_rdy[0], 1);
    chk("t1_dispatch_mop", t_mop[1], 8'h31);
    for (int k = 0; k < 4; k++) begin
      chk("t1_valid", t_v[2+k], 1);
      chk("t1_uaddr", t_ua[2+k], k + 1);
      chk("t1_incpc", t_inc[2+k], e_inc1[k]);
    end
    chk("t1_fetch_rdy", t_rdy[6], 1);
    chk("t1_fetch_valid", t_v[6], 0);

    // Stall at uPC=2
    run_trace(11, 8'h31, 8'h00, 32'h1, 32'b111000, 32'h0, 32'h0, 32'h0);
    for (int k = 3; k < 6; k++) begin
      chk("t2_stall_uaddr", t_ua[k], 2);
      chk("t2_stall_valid", t_v[k], 0);
      chk("t2_stall_incpc", t_inc[k], 0);
    end
    chk("t2_resume_uaddr", t_ua[6], 2); chk("t2_resume_inc", t_inc[6], 1);
    chk("t2_next_uaddr", t_ua[7], 3);   chk("t2_next_inc", t_inc[7], 0);
    chk("t2_last_uaddr", t_ua[8], 4);   chk("t2_fetch_rdy", t_rdy[9], 1);

    // Conditional EOF on Z
    plut[8'h40] = 8'd19;
    rom[19] = mk_uop(FL_INC_EOF_Z, 8'h19); rom[20] = mk_uop(FL_OP, 8'h20);
    rom[21] = mk_uop(FL_OP, 8'h21);        rom[22] = mk_uop(FL_EOF, 8'h22);
    run_trace(5, 8'h40, 8'h00, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0);
    chk("t3z_uaddr", t_ua[2], 19); chk("t3z_inc", t_inc[2], 1);
    chk("t3z_fetch_rdy", t_rdy[3], 1);
    run_trace(8, 8'h40, 8'h00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t3nz_inc", t_inc[2], 1);
    chk("t3nz_ua20", t_ua[3], 20); chk("t3nz_ua21", t_ua[4], 21);
    chk("t3nz_ua22", t_ua[5], 22); chk("t3nz_fetch_rdy", t_rdy[6], 1);

    // JCB with the CB byte arriving late
    plut[8'hCB] = 8'd15; rom[15] = mk_uop(FL_JCB, 8'h15);
    cblut[8'h7C] = 8'd16; rom[16] = mk_uop(FL_INC_EOF, 8'h16);
    run_trace(9, 8'hCB, 8'h7C, 32'b10001, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t4_hold_valid", t_v[2], 1);  chk("t4_hold_inc", t_inc[2], 0);
    chk("t4_hold_inc2", t_inc[3], 0); chk("t4_hold_ua", t_ua[3], 15);
    chk("t4_accept_inc", t_inc[4], 1); chk("t4_accept_rdy", t_rdy[4], 1);
    chk("t4_cb_page", t_cb[5], 1);    chk("t4_cb_mop", t_mop[5], 8'h7C);
    chk("t4_cb_uaddr", t_ua[6], 16);  chk("t4_fetch_rdy", t_rdy[7], 1);

    // Interrupt entry on terminal only
    plut[8'h55] = 8'd30; rom[30] = mk_uop(FL_OP, 8'h30); rom[31] = mk_uop(FL_EOF, 8'h31);
    rom[8'hF0] = mk_uop(FL_INC_EOF, 8'hF0);
    run_trace(7, 8'h55, 8'h00, 32'h1, 32'h0, 32'h0, 32'b1100, 32'h0);
    chk("t5_no_ack_nonterm", t_ack[2], 0); chk("t5_ack_eof", t_ack[3], 1);
    chk("t5_irq_uaddr", t_ua[4], 8'hF0);   chk("t5_no_fetch", t_rdy[4], 0);
    chk("t5_ack_once", t_ack[4], 0);       chk("t5_fetch_rdy", t_rdy[5], 1);

    // Illegal flow code, sticky error, reset mid-flow
    plut[8'h66] = 8'd5; rom[5] = mk_uop(4'hF, 8'h05);
    run_trace(5, 8'h66, 8'h00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t6_err_before", t_err[2], 0); chk("t6_err_after", t_err[3], 1);
    chk("t6_err_fetch", t_rdy[3], 1);
    run_trace(8, 8'h31, 8'h00, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("t6_err_sticky", t_err[7], 1);
    run_trace(7, 8'h31, 8'h00, 32'h1, 32'h0, 32'h0, 32'h0, 32'b1000);
    chk("t6_rst_valid", t_v[3], 0);  chk("t6_rst_inc", t_inc[3], 0);
    chk("t6_rst_rdy", t_rdy[3], 0);
    chk("t6_post_err", t_err[4], 0); chk("t6_post_ua", t_ua[4], 0);
    chk("t6_post_busy", t_busy[4], 0); chk("t6_post_idle_rdy", t_rdy[4], 0);
    chk("t6_post_fetch", t_rdy[5], 1);

    // Randomised traffic against the model
    for (int i = 0; i < 256; i++) begin
      rom[i] = rand_uop(); plut[i] = 8'($urandom); cblut[i] = 8'($urandom);
    end
    for (int c = 0; c < 5000; c++) begin
      iStall      = ($urandom_range(0, 99) < 20);
      iOpValid    = 1'($urandom_range(0, 1));
      iOpcode     = 8'($urandom);
      iZero       = 1'($urandom_range(0, 1));
      iIrqPending = ($urandom_range(0, 99) < 10);
      iReset      = ($urandom_range(0, 199) == 0);
      @(posedge iClock); #1;
    end
    iStall = 0; iOpValid = 0; iIrqPending = 0; iReset = 0;
    repeat (4) @(posedge iClock);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
